seq_arb_detect: RTL and testbench

Time-multiplexed controller that shares a single Mealy overlapping "1101" sequence-detector datapath among NUM_CH serial bit lanes. A round-robin arbiter grants one requesting lane per cycle, restores that lane's saved detector state, advances it by the granted bit, and writes it back. A registered match pulse tagged with the lane number is produced. It sits between the serial-input front ends and the event/interrupt logic.

---
 rtl/seq_arb_detect.sv | 119 +++++++++++
 tb/tb_seq_arb_detect.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_arb_detect.sv
// Round-robin time-multiplexed "1101" overlapping Mealy detector shared by NUM_CH serial lanes.
// Optional per-lane saturating match counters are built when SEQ_ARB_CNT_EN is defined.
module seq_arb_detect #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [NUM_CH-1:0] in_bit,
  input  logic [NUM_CH-1:0] clr_ch,
  output logic [NUM_CH-1:0] in_ready,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [7:0]        cnt_out
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_e;

  det_state_e      ctx_q [NUM_CH];
  det_state_e      ctx_d [NUM_CH];
  det_state_e      cur_s;
  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;
  logic [CH_W-1:0] scan_idx;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            gnt_bit;
  logic            match_c;

  // Round-robin search starting one past the last granted lane; cleared lanes are skipped
  always_comb begin
    in_ready = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      scan_idx = CH_W'((32'(ptr_q) + k) % NUM_CH);
      if (!gnt_any && !rst && in_valid[scan_idx] && !clr_ch[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (gnt_any) in_ready[gnt_idx] = 1'b1;
  end

  // Shared detector datapath: restore granted lane context, advance by one bit
  always_comb begin
    ctx_d   = ctx_q;
    ptr_d   = ptr_q;
    match_c = 1'b0;
    cur_s   = ctx_q[gnt_idx];
    gnt_bit = in_bit[gnt_idx];
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (clr_ch[i]) ctx_d[i] = S0;
    end
    if (gnt_any) begin
      ptr_d = gnt_idx;
      unique case (cur_s)
        S0: ctx_d[gnt_idx] = gnt_bit ? S1 : S0;
        S1: ctx_d[gnt_idx] = gnt_bit ? S2 : S0;
        S2: ctx_d[gnt_idx] = gnt_bit ? S2 : S3;
        S3: begin
          ctx_d[gnt_idx] = gnt_bit ? S1 : S0;
          match_c        = gnt_bit;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) ctx_q[i] <= S0;
      ptr_q       <= CH_W'(NUM_CH - 1);
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      ctx_q       <= ctx_d;
      ptr_q       <= ptr_d;
      match_valid <= match_c;
      if (match_c) match_ch <= gnt_idx;
    end
  end

`ifdef SEQ_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  // Saturating per-lane match counters; a lane is never granted while being cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (clr_ch[i]) begin
          cnt_q[i] <= '0;
        end else if (match_c && (gnt_idx == CH_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_out = cnt_q[cnt_sel];
`else
  logic unused_cnt_sel;

  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = CNT_W'(0);
`endif

endmodule

// File: tb/tb_seq_arb_detect.sv
// Self-checking bench for seq_arb_detect: directed scenarios followed by randomized traffic,
// compared against a per-lane "last four bits" history model.
module tb_seq_arb_detect;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_bit;
  logic [NUM_CH-1:0] clr_ch;
  logic [NUM_CH-1:0] in_ready;
  logic              match_valid;
  logic [CH_W-1:0]   match_ch;
  logic [CH_W-1:0]   cnt_sel;
  logic [7:0]        cnt_out;

  seq_arb_detect #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .clr_ch     (clr_ch),
    .in_ready   (in_ready),
    .match_valid(match_valid),
    .match_ch   (match_ch),
    .cnt_sel    (cnt_sel),
    .cnt_out    (cnt_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: last four delivered bits per lane, last granted lane, counters
  logic [3:0] hist [NUM_CH] = '{default: 4'b0};
  int         mcnt [NUM_CH] = '{default: 0};
  int         mptr = NUM_CH - 1;
  logic       exp_mv = 1'b0;
  int         exp_mch = 0;

  int         last_grant;
  logic [NUM_CH-1:0] last_rdy;
  int         last_cnt;
  int         n_match;
  int         last_mch;

`ifdef SEQ_ARB_CNT_EN
  localparam int CNT_FULL = 255;
`else
  localparam int CNT_FULL = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Eligible lane closest (cyclically) after the last granted lane
  function automatic int model_grant();
    int best  = -1;
    int bestd = NUM_CH;
    if (rst) return -1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_valid[i] && !clr_ch[i]) begin
        int d = (i - mptr - 1 + 2 * int'(NUM_CH)) % int'(NUM_CH);
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_update(input int g);
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hist[i] = 4'b0;
        mcnt[i] = 0;
      end
      mptr    = NUM_CH - 1;
      exp_mv  = 1'b0;
      exp_mch = 0;
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr_ch[i]) begin
        hist[i] = 4'b0;
        mcnt[i] = 0;
      end
    end
    exp_mv = 1'b0;
    if (g >= 0) begin
      hist[g] = {hist[g][2:0], in_bit[g]};
      mptr    = g;
      if (hist[g] == 4'b1101) begin
        exp_mv  = 1'b1;
        exp_mch = g;
        if (mcnt[g] < 255) mcnt[g]++;
      end
    end
  endtask

  // One clock: check combinational outputs mid-cycle, registered outputs after the edge
  task automatic tick();
    int g;
    logic [NUM_CH-1:0] exp_rdy;
    @(negedge clk);
    g       = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    last_grant = -1;
    for (int i = 0; i < NUM_CH; i++) if (in_ready[i]) last_grant = i;
    last_rdy = in_ready;
    last_cnt = int'(cnt_out);
    if (!rst) begin
`ifdef SEQ_ARB_CNT_EN
      chk("cnt_out", 32'(cnt_out), 32'(mcnt[cnt_sel]));
`else
      chk("cnt_out", 32'(cnt_out), 32'(0));
`endif
    end
    model_update(g);
    @(posedge clk);
    #1;
    chk("match_valid", 32'(match_valid), 32'(exp_mv));
    chk("match_ch", 32'(match_ch), 32'(exp_mch));
    if (match_valid) begin
      n_match++;
      last_mch = int'(match_ch);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_bit = '0; clr_ch = '0;
    tick();
    rst = 1'b0;
    n_match = 0;
  endtask

  logic [6:0] s1 = 7'b1101101;
  logic [3:0] p1 = 4'b1101;
  logic [3:0] p2 = 4'b1100;
  logic [2:0] pre = 3'b110;

  initial begin
    rst = 1'b1; in_valid = '0; in_bit = '0; clr_ch = '0; cnt_sel = '0;
    n_match = 0; last_mch = 0;
    tick();
    tick();
    chk("reset_mv", 32'(match_valid), 32'(0));
    chk("reset_mch", 32'(match_ch), 32'(0));
    rst = 1'b0;

    // Single lane, overlapping matches
    n_match = 0;
    for (int j = 0; j < 7; j++) begin
      in_valid = 4'b0001; in_bit = '0; in_bit[0] = s1[6-j];
      tick();
    end
    in_valid = '0;
    tick();
    chk("single_matches", 32'(n_match), 32'(2));
    chk("single_ch", 32'(last_mch), 32'(0));

    // Round robin from reset
    do_reset();
    in_valid = 4'b1111; in_bit = '0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("rr_grant", 32'(last_grant), 32'(j % 4));
    end

    // Context isolation between interleaved lanes
    do_reset();
    for (int j = 0; j < 4; j++) begin
      in_valid = 4'b0010; in_bit = '0; in_bit[1] = p1[3-j];
      tick();
      in_valid = 4'b0100; in_bit = '0; in_bit[2] = p2[3-j];
      tick();
    end
    in_valid = '0;
    tick();
    chk("iso_matches", 32'(n_match), 32'(1));
    chk("iso_ch", 32'(last_mch), 32'(1));

    // Clear kills the prefix and blocks the grant
    do_reset();
    for (int j = 0; j < 3; j++) begin
      in_valid = 4'b1000; in_bit = '0; in_bit[3] = pre[2-j];
      tick();
    end
    clr_ch = 4'b1000; in_bit = 4'b1000;
    tick();
    chk("clr_no_grant", 32'(last_rdy[3]), 32'(0));
    clr_ch = '0;
    tick();
    in_valid = '0;
    tick();
    chk("clr_matches", 32'(n_match), 32'(0));

    // Gap in valid keeps the prefix
    do_reset();
    for (int j = 0; j < 3; j++) begin
      in_valid = 4'b1000; in_bit = '0; in_bit[3] = pre[2-j];
      tick();
    end
    in_valid = '0;
    repeat (5) tick();
    in_valid = 4'b1000; in_bit = 4'b1000;
    tick();
    in_valid = '0;
    tick();
    chk("gap_matches", 32'(n_match), 32'(1));
    chk("gap_ch", 32'(last_mch), 32'(3));

    // Reset mid-pattern
    do_reset();
    for (int j = 0; j < 3; j++) begin
      in_valid = 4'b0001; in_bit = '0; in_bit[0] = pre[2-j];
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 4'b1111; in_bit = 4'b0001;
    tick();
    chk("rst_ptr_grant", 32'(last_grant), 32'(0));
    in_valid = '0;
    tick();
    chk("rst_matches", 32'(n_match), 32'(0));

    // Counter saturation and clear
    do_reset();
    cnt_sel = CH_W'(2);
    in_valid = 4'b0100; in_bit = 4'b0100;
    tick();
    for (int j = 0; j < 300; j++) begin
      for (int b = 0; b < 3; b++) begin
        in_bit = '0; in_bit[2] = pre[b];
        in_bit[2] = (b != 1);
        tick();
      end
    end
    in_valid = '0;
    tick();
    tick();
    chk("cnt_matches", 32'(n_match), 32'(300));
    chk("cnt_sat", 32'(last_cnt), 32'(CNT_FULL));
    clr_ch = 4'b0100;
    tick();
    clr_ch = '0;
    tick();
    chk("cnt_clr", 32'(last_cnt), 32'(0));

    // Randomized traffic against the model
    do_reset();
    for (int j = 0; j < 2000; j++) begin
      rst      = ($urandom_range(0, 63) == 0);
      in_valid = NUM_CH'($urandom);
      in_bit   = NUM_CH'($urandom);
      clr_ch   = '0;
      for (int i = 0; i < NUM_CH; i++) clr_ch[i] = ($urandom_range(0, 15) == 0);
      cnt_sel  = CH_W'($urandom_range(0, NUM_CH - 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
